// File: rtl/bitty_uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and divisor limits,
// also used by the TX side and the control block.
package bitty_uart_rx_pkg;

  localparam int UART_CPB_W     = 13;
  localparam int UART_CPB_MIN   = 2;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/bitty_uart_rx_if.sv
// Valid/ready byte stream from the UART receiver to its consumer.
interface bitty_uart_rx_if;
  import bitty_uart_rx_pkg::*;

  logic                      rx_valid;
  logic                      rx_ready;
  logic [UART_DATA_BITS-1:0] rx_data;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/bitty_uart_rx_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs, one flop pair per bit,
// with a per-bit reset value so idle-high lines come out of reset idle.
module bitty_uart_rx_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
      if (srst) begin
        meta_reg <= RESET_VAL[gi];
        sync_reg <= RESET_VAL[gi];
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/bitty_uart_rx.sv
// 8N1 UART receiver: oversampled framing FSM, 1-deep output buffer on a
// valid/ready stream, framing-error pulse and sticky overrun flag.
module bitty_uart_rx
  import bitty_uart_rx_pkg::*;
#(
  parameter int CPB_W     = UART_CPB_W,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CPB_W-1:0]     clks_per_bit,
  input  logic                 rx_data_bit,
  bitty_uart_rx_if.master      rx_bus,
  output logic                 framing_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  logic                 rx_s;
  rx_state_t            state_reg, state_next;
  logic [CPB_W-1:0]     cnt_reg, cnt_next;
  logic [CPB_W-1:0]     cpb_q_reg, cpb_q_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] sh_reg, sh_next;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 framing_err_reg;
  logic                 overrun_reg;
  logic                 deliver;
  logic                 stop_bad;
  logic [CPB_W-1:0]     cpb_eff;
  logic [CPB_W-1:0]     half_m1;
  logic [CPB_W-1:0]     full_m1;
  logic                 consume;

  bitty_uart_rx_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .srst (reset),
    .d    (rx_data_bit),
    .q    (rx_s)
  );

  // Divisors below 2 would leave no room for a mid-bit sample.
  assign cpb_eff = (clks_per_bit < CPB_W'(UART_CPB_MIN)) ? CPB_W'(UART_CPB_MIN) : clks_per_bit;
  assign half_m1 = (cpb_q_reg >> 1) - CPB_W'(1);
  assign full_m1 = cpb_q_reg - CPB_W'(1);
  assign consume = rx_valid_reg && rx_bus.rx_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CPB_W'(1);
    cpb_q_next = cpb_q_reg;
    idx_next   = idx_reg;
    sh_next    = sh_reg;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          cpb_q_next = cpb_eff;
          state_next = ST_START;
        end
      end
      ST_START: begin
        // Re-check the line half a bit in; a short low pulse is a glitch.
        if (cnt_reg == half_m1) begin
          cnt_next   = '0;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg == full_m1) begin
          cnt_next         = '0;
          sh_next[idx_reg] = rx_s;
          idx_next         = idx_reg + IDX_W'(1);
          if (idx_reg == IDX_W'(DATA_BITS - 1)) begin
            idx_next   = '0;
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_reg == full_m1) begin
          cnt_next = '0;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before another start is accepted.
        cnt_next = '0;
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      cpb_q_reg       <= '0;
      idx_reg         <= '0;
      sh_reg          <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      framing_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      cpb_q_reg       <= cpb_q_next;
      idx_reg         <= idx_next;
      sh_reg          <= sh_next;
      framing_err_reg <= stop_bad;
      // A byte landing while the old one is being taken replaces it seamlessly.
      if (deliver && (!rx_valid_reg || rx_bus.rx_ready)) begin
        rx_data_reg  <= sh_reg;
        rx_valid_reg <= 1'b1;
      end else if (consume) begin
        rx_valid_reg <= 1'b0;
      end
      if (deliver && rx_valid_reg && !rx_bus.rx_ready) begin
        overrun_reg <= 1'b1;
      end else if (err_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_valid = rx_valid_reg;
  assign rx_bus.rx_data  = rx_data_reg;
  assign framing_err     = framing_err_reg;
  assign overrun         = overrun_reg;
  assign busy            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bitty_uart_rx.sv
// Bench for bitty_uart_rx: a queue of expected bytes is checked at every
// transfer, with directed frame scenarios plus randomized frames.
module tb_bitty_uart_rx;

  logic        clk;
  logic        reset;
  logic [12:0] clks_per_bit;
  logic        rx_line;
  logic        framing_err;
  logic        overrun;
  logic        err_clr;
  logic        busy;

  bitty_uart_rx_if bus ();

  bitty_uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .clks_per_bit (clks_per_bit),
    .rx_data_bit  (rx_line),
    .rx_bus       (bus),
    .framing_err  (framing_err),
    .overrun      (overrun),
    .err_clr      (err_clr),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total_cnt = 0;
  int         pass_cnt  = 0;
  int         fe_cnt    = 0;
  int         xfer_cnt  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    total_cnt++;
    if (val >= lo && val <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
  endtask

  // Called at a falling clock edge; holds each bit for cpb cycles.
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = fr[i];
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every transfer must match the oldest expected byte; a held
  // byte must not change or vanish before it is taken.
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_b;
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (framing_err) fe_cnt++;
      if (hold_prev) begin
        chk("held_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("held_data", {24'd0, bus.rx_data}, {24'd0, prev_data});
      end
      if (bus.rx_valid && bus.rx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          chk("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_b});
        end
      end
      hold_prev = bus.rx_valid && !bus.rx_ready;
      prev_data = bus.rx_data;
    end
  end

  int  n;
  int  x0;
  int  f0;
  int  v;
  int  eff;
  bit  got;
  bit  saw_busy;
  logic [7:0] rb;

  initial begin
    reset        = 1'b1;
    rx_line      = 1'b1;
    bus.rx_ready = 1'b1;
    err_clr      = 1'b0;
    clks_per_bit = 13'd8;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_framing_err", {31'd0, framing_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(10);

    // 0xA5 at cpb 8: one byte, with rx_valid about 79 cycles after the edge.
    exp_q.push_back(8'hA5);
    x0 = xfer_cnt;
    fork
      send_frame(8'hA5, 8, 1'b1);
      begin
        n = 0;
        got = 1'b0;
        while (!got && n < 120) begin
          @(posedge clk);
          #1;
          n++;
          if (bus.rx_valid) begin
            got = 1'b1;
            chk("a5_literal", {24'd0, bus.rx_data}, 32'hA5);
          end
        end
      end
    join
    chk_range("a5_latency", n, 78, 80);
    idle(20);
    chk("a5_count", xfer_cnt - x0, 32'd1);
    chk("a5_framing_err", fe_cnt, 32'd0);
    chk("a5_overrun", {31'd0, overrun}, 32'd0);

    // 3-cycle low glitch: start aborts, no byte, busy drops soon after.
    x0 = xfer_cnt;
    saw_busy = 1'b0;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    chk("glitch_busy_clear", {31'd0, busy}, 32'd0);
    @(negedge clk);
    idle(20);
    chk("glitch_no_byte", xfer_cnt - x0, 32'd0);

    // Stop bit low at cpb 16, then a 100-cycle break, then a clean 0x81.
    clks_per_bit = 13'd16;
    f0 = fe_cnt;
    x0 = xfer_cnt;
    send_frame(8'h3C, 16, 1'b0);
    rx_line = 1'b0;
    repeat (100) @(negedge clk);
    idle(20);
    chk("fe_pulse_once", fe_cnt - f0, 32'd1);
    chk("fe_no_byte", xfer_cnt - x0, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 16, 1'b1);
    idle(30);
    chk("after_break_byte", xfer_cnt - x0, 32'd1);
    chk("after_break_fe", fe_cnt - f0, 32'd1);

    // Overrun: 0x22 arrives while 0x11 is still held.
    clks_per_bit = 13'd8;
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 8, 1'b1);
    idle(4);
    send_frame(8'h22, 8, 1'b1);
    idle(20);
    #1;
    chk("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("ovr_data_kept", {24'd0, bus.rx_data}, 32'h11);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("ovr_clr_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("ovr_clr_flag", {31'd0, overrun}, 32'd0);
    @(negedge clk);

    // Take 0x11 in the very cycle 0x22 completes: no overrun, 0x22 follows.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 8, 1'b1);
    idle(4);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 8, 1'b1);
      begin
        repeat (78) @(posedge clk);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    idle(5);
    #1;
    chk("same_cycle_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("same_cycle_data", {24'd0, bus.rx_data}, 32'h22);
    chk("same_cycle_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    bus.rx_ready = 1'b1;
    idle(5);
    #1;
    chk("same_cycle_drained", {31'd0, bus.rx_valid}, 32'd0);
    @(negedge clk);

    // Divisors 0 and 1 run as 2.
    x0 = xfer_cnt;
    clks_per_bit = 13'd0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 2, 1'b1);
    idle(10);
    clks_per_bit = 13'd1;
    exp_q.push_back(8'hE7);
    send_frame(8'hE7, 2, 1'b1);
    idle(10);
    chk("cpb_small_count", xfer_cnt - x0, 32'd2);

    // Divisor change mid-frame only affects the next frame.
    x0 = xfer_cnt;
    clks_per_bit = 13'd8;
    exp_q.push_back(8'h96);
    fork
      send_frame(8'h96, 8, 1'b1);
      begin
        repeat (30) @(negedge clk);
        clks_per_bit = 13'd20;
      end
    join
    idle(20);
    exp_q.push_back(8'h4B);
    send_frame(8'h4B, 20, 1'b1);
    idle(30);
    chk("cpb_change_count", xfer_cnt - x0, 32'd2);

    // Randomized frames with a mostly-ready consumer.
    x0 = xfer_cnt;
    for (int f = 0; f < 24; f++) begin
      v   = $urandom_range(0, 20);
      eff = (v < 2) ? 2 : v;
      rb  = 8'($urandom);
      clks_per_bit = 13'(v);
      exp_q.push_back(rb);
      fork
        send_frame(rb, eff, 1'b1);
        begin
          for (int k = 0; k < 10 * eff; k++) begin
            bus.rx_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
          end
        end
      join
      bus.rx_ready = 1'b1;
      idle($urandom_range(1, 8));
    end
    idle(40);
    chk("random_count", xfer_cnt - x0, 32'd24);
    chk("random_overrun", {31'd0, overrun}, 32'd0);

    // Reset in the middle of the data bits abandons the frame.
    clks_per_bit = 13'd8;
    rx_line = 1'b0;
    repeat (8 + 24) @(negedge clk);
    reset   = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("midrst_data", {24'd0, bus.rx_data}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    chk("midrst_framing_err", {31'd0, framing_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    x0 = xfer_cnt;
    idle(30);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 8, 1'b1);
    idle(30);
    chk("midrst_next_byte", xfer_cnt - x0, 32'd1);

    idle(20);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("total_framing_errs", fe_cnt, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
